// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store initiator.
// Pure declarations: no latency or backpressure of its own.
// Used by lsu_mem_master and lsu_align.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LSU_BASE_ADDR = 32'h0000_2000;
    localparam logic [31:0] LSU_END_ADDR  = 32'h0000_3FFF;

    // Stores only have signed size codes; the unsigned variants are load-only.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are consumed.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = '0;
        endcase
    end

    // Lanes not addressed by the store pass through from the read word.
    always_comb begin
        merged = rdata;
        case (funct3)
            F3_B: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            F3_W:    merged = wdata;
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one B/H/W request at a time onto a word-wide 1-cycle-read memory.
// Latency accept->rsp: error 1, word store 2, load 3, sub-word store (RMW) 4 cycles.
// Single outstanding request: req_ready only in IDLE; response held until rsp_ready.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = LSU_BASE_ADDR,
    parameter logic [31:0] END_ADDR  = LSU_END_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_t  state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        req_fire;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_fire     = i_req_valid && (state == S_IDLE);
    assign out_of_range = (i_req_addr < BASE_ADDR) || (i_req_addr > END_ADDR);
    assign req_err      = out_of_range
                       || !f3_legal(i_req_funct3, i_req_we)
                       || is_misaligned(i_req_funct3, i_req_addr[1:0]);

    lsu_align u_align (
        .rdata     (i_mem_rdata),
        .offset    (off_q),
        .funct3    (f3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        off_q       <= i_req_addr[1:0];
                        f3_q        <= i_req_funct3;
                        we_q        <= i_req_we;
                        wdata_q     <= i_req_wdata;
                        mem_addr_q  <= {i_req_addr[31:2], 2'b00};
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_err;
                        if (req_err) begin
                            state <= S_RESP;
                        end else if (i_req_we && (i_req_funct3 == F3_W)) begin
                            mem_wdata_q <= i_req_wdata;
                            state       <= S_WR;
                        end else begin
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: state <= S_RD_DATA;
                // Read word is on i_mem_rdata here: finish the load or build the RMW word.
                S_RD_DATA: begin
                    if (we_q) begin
                        mem_wdata_q <= merged;
                        state       <= S_WR;
                    end else begin
                        rsp_rdata_q <= load_data;
                        state       <= S_RESP;
                    end
                end
                S_WR: state <= S_RESP;
                S_RESP: begin
                    if (i_rsp_ready) begin
                        mem_addr_q <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state == S_IDLE);
    assign o_rsp_valid = (state == S_RESP);
    assign o_mem_wren  = (state == S_WR);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the core's execute stage and the 8 KiB data memory. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake and checks its range and alignment. It issues word-wide accesses to the memory's single-port, 1-cycle-read interface, performing read-modify-write for sub-word stores. It returns a sign- or zero-extended load result, or an error flag, over a valid/ready response channel.

## Interface
- BASE_ADDR, 32'h2000, lowest legal byte address
- END_ADDR, 32'h3FFF, highest legal byte address
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  block can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data; the low byte or low halfword is used for sub-word stores
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned, out-of-range or illegal funct3
- o_mem_addr  out  32  word-aligned byte address, [1:0] = 2'b00
- o_mem_wren  out  1  memory write enable
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data; valid the cycle after its address was driven

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- o_req_ready = (state == IDLE). Acceptance is i_req_valid & o_req_ready; all request fields are captured in that cycle.
- Error check at acceptance. Any of the following sends the block IDLE -> RESP with err=1, rdata=0 and no memory access:
  - address outside [BASE_ADDR, END_ADDR]
  - halfword access with addr[0]=1
  - word access with addr[1:0]≠0
  - illegal funct3 (011, 110 or 111; any 1xx for a store)
- Load path: IDLE -> RD_ADDR (drive o_mem_addr) -> RD_DATA (select the lane by addr[1:0], extend, register into the response) -> RESP.
  - Byte lane k = rdata[8k+7:8k]; halfword lane = rdata[16·addr[1]+15 : 16·addr[1]].
  - B/H sign-extend; BU/HU zero-extend.
- Word store path: IDLE -> WR (o_mem_wren=1, o_mem_wdata=wdata) -> RESP.
- Sub-word store path: IDLE -> RD_ADDR -> RD_DATA (merge the new byte/halfword into the read word, register it) -> WR -> RESP. Unselected lanes are written back unchanged.
- RESP: o_rsp_valid=1, with data and err held stable until i_rsp_ready. The handshake returns the block to IDLE; the next request is accepted no earlier than the following cycle.
- o_mem_addr holds its captured value in every non-IDLE state and is 0 in IDLE. o_mem_wren=1 only in WR.

## Timing
- Latency from the acceptance edge to o_rsp_valid:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Throughput: one request per (latency + 1) cycles when i_rsp_ready is held high.
- Reset values: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_addr=0, o_mem_wren=0, o_mem_wdata=0.
- o_mem_wren and o_rsp_valid are decoded from the state register, so assertion of i_rst_n=0 drops them immediately.
- Reset mid-operation aborts the transaction with no response. A reset in RD_ADDR or RD_DATA means no write occurs.
- i_req_valid while not ready is ignored; the requester must hold the request.
- Address exactly END_ADDR with word size: error (misaligned). Address END_ADDR-3 with word size: legal.

## Structure
- Package lsu_pkg:
  - state enum
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - default BASE_ADDR and END_ADDR constants
- Sub-module lsu_align (combinational):
  - load lane extraction and extension: (rdata, addr[1:0], funct3) -> data
  - store merge: (old word, new data, addr[1:0], funct3) -> word
- The FSM, the capture registers and the handshake logic stay in lsu_mem_master.

## Test plan
- Preload word 0x2004 = 32'h8011_22F0; LB @0x2004 -> rsp rdata 32'hFFFF_FFF0, err 0, valid exactly 3 cycles after accept.
- Same word; LHU @0x2006 -> 32'h0000_8011; LH @0x2006 -> 32'hFFFF_8011.
- SB wdata 32'h0000_00AB @0x2005 on word 32'h1122_3344 -> exactly one write cycle with o_mem_wdata 32'h1122_AB44, response 4 cycles after accept; a following LW @0x2004 returns 32'h1122_AB44.
- LW @0x2002 (misaligned), SW @0x1FFC (below range) and funct3 011 -> each gives err=1, rdata 0, 1-cycle latency, o_mem_wren never asserted.
- Hold i_rsp_ready=0 for 5 cycles after an LW -> valid, rdata and err stable throughout and o_req_ready=0; a request presented during the stall is accepted only after the response handshake.
- Assert i_rst_n=0 during the RD_DATA of an SH -> o_mem_wren stays 0, no response is issued, the memory word is unchanged, and o_req_ready=1 after reset release.
